// File: rtl/payload_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : payload_buffer_if
// Brief    : Host write port and encapsulator drain port of payload_buffer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface payload_buffer_if #(
  parameter int CNT_W = 11
) ();
  logic [7:0]       wr_data;
  logic             wr_en;
  logic             wr_last;
  logic             wr_ready;
  logic [7:0]       data_in;
  logic             read_en;
  logic             buffer_ready;
  logic             buffer_empt;
  logic             data_recived;
  logic [CNT_W-1:0] len_out;
  logic             ovf_err;

  // Host and encapsulator side
  modport master (
    output wr_data, wr_en, wr_last, data_recived,
    input  wr_ready, data_in, read_en, buffer_ready, buffer_empt, len_out, ovf_err
  );

  // Buffer side
  modport slave (
    input  wr_data, wr_en, wr_last, data_recived,
    output wr_ready, data_in, read_en, buffer_ready, buffer_empt, len_out, ovf_err
  );
endinterface
`default_nettype wire

// File: rtl/payload_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : payload_buffer
// Brief    : Single-frame payload store. Fills from the host, advertises a
//            committed payload, bursts it out on acknowledge, then recovers.
//            Macro PAYLOAD_BUF_DROP_EN selects drop-on-overflow; without it
//            an oversized payload is truncated to DEPTH bytes.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module payload_buffer #(
  parameter int DEPTH = 1500,
  parameter int CNT_W = 11
) (
  input  wire logic       clk,
  input  wire logic       rst,
  payload_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [7:0]       data_in_q, data_in_d;
  logic             wr_ready_q, wr_ready_d;
  logic             read_en_q, read_en_d;
  logic             buffer_ready_q, buffer_ready_d;
  logic             buffer_empt_q, buffer_empt_d;
  logic             ovf_q, ovf_d;
`ifdef PAYLOAD_BUF_DROP_EN
  logic             drop_q, drop_d;
`endif

  logic [7:0]       mem [DEPTH];
  logic             mem_we;
  logic             full;
  logic [CNT_W-1:0] rd_addr;
  logic [7:0]       rd_byte;

  assign full    = (wr_ptr_q == DEPTH_C);
  // Byte 0 is fetched on the acknowledge edge so the first strobe carries data.
  assign rd_addr = (state_q == READY) ? '0 : rd_ptr_q;
  assign rd_byte = mem[rd_addr];

  // Next-state, pointer and registered-output computation
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    len_d     = len_q;
    data_in_d = data_in_q;
    ovf_d     = 1'b0;
    mem_we    = 1'b0;
`ifdef PAYLOAD_BUF_DROP_EN
    drop_d    = drop_q;
`endif
    case (state_q)
      FILL: begin
        if (bus.wr_en) begin
`ifdef PAYLOAD_BUF_DROP_EN
          if (drop_q) begin
            // swallow the tail of a discarded payload
            if (bus.wr_last) drop_d = 1'b0;
          end else if (full) begin
            ovf_d    = 1'b1;
            wr_ptr_d = '0;
            drop_d   = ~bus.wr_last;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE_C;
            if (bus.wr_last) begin
              state_d = READY;
              len_d   = wr_ptr_q + ONE_C;
            end
          end
`else
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE_C;
          end
          if (bus.wr_last) begin
            state_d = READY;
            len_d   = full ? DEPTH_C : wr_ptr_q + ONE_C;
          end
`endif
        end
      end
      READY: begin
        if (bus.data_recived) begin
          state_d   = DRAIN;
          data_in_d = rd_byte;
          rd_ptr_d  = ONE_C;
        end
      end
      DRAIN: begin
        // rd_ptr_q counts bytes already presented
        if (rd_ptr_q == len_q) begin
          state_d = DONE;
        end else begin
          data_in_d = rd_byte;
          rd_ptr_d  = rd_ptr_q + ONE_C;
        end
      end
      DONE: begin
        state_d  = FILL;
        wr_ptr_d = '0;
      end
      default: state_d = FILL;
    endcase
    wr_ready_d     = (state_d == FILL);
    read_en_d      = (state_d == DRAIN);
    buffer_ready_d = (state_d == READY);
    buffer_empt_d  = (state_d == DONE);
  end

  // State, pointer and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= FILL;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      len_q          <= '0;
      data_in_q      <= '0;
      wr_ready_q     <= 1'b1;
      read_en_q      <= 1'b0;
      buffer_ready_q <= 1'b0;
      buffer_empt_q  <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      len_q          <= len_d;
      data_in_q      <= data_in_d;
      wr_ready_q     <= wr_ready_d;
      read_en_q      <= read_en_d;
      buffer_ready_q <= buffer_ready_d;
      buffer_empt_q  <= buffer_empt_d;
      ovf_q          <= ovf_d;
    end
  end

`ifdef PAYLOAD_BUF_DROP_EN
  // Discard-in-progress flag for drop mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= 1'b0;
    else      drop_q <= drop_d;
  end
`endif

  // Payload storage; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.wr_ready     = wr_ready_q;
  assign bus.data_in      = data_in_q;
  assign bus.read_en      = read_en_q;
  assign bus.buffer_ready = buffer_ready_q;
  assign bus.buffer_empt  = buffer_empt_q;
  assign bus.len_out      = len_q;
  assign bus.ovf_err      = ovf_q;

endmodule
`default_nettype wire
